seg7_scan: RTL and testbench

Downstream display stage for the SCPU core: consumes the 32-bit value the CPU publishes for display and time-multiplexes it onto an 8-digit common-anode seven-segment panel. It drives the `a2g`/`an` pins that the top level exposes. The value is double-buffered so a displayed frame never tears. The block also provides optional leading-zero blanking and a dead-time guard between digits against ghosting.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_dec.sv | 30 +++
 rtl/seg7_scan.sv | 117 +++++++++++
 tb/tb_seg7_scan.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the eight-digit seven-segment scanner.
package seg7_pkg;

    localparam int DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } seg7_state_t;

endpackage

// File: rtl/seg7_dec.sv
// Hex nibble to active-low seven-segment pattern, bit 6 = segment a, bit 0 = segment g.
module seg7_dec (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        unique case (i_nibble)
            4'h0: o_seg = 7'b0000001;
            4'h1: o_seg = 7'b1001111;
            4'h2: o_seg = 7'b0010010;
            4'h3: o_seg = 7'b0000110;
            4'h4: o_seg = 7'b1001100;
            4'h5: o_seg = 7'b0100100;
            4'h6: o_seg = 7'b0100000;
            4'h7: o_seg = 7'b0001111;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0000100;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b1100000;
            4'hC: o_seg = 7'b0110001;
            4'hD: o_seg = 7'b1000010;
            4'hE: o_seg = 7'b0110000;
            4'hF: o_seg = 7'b0111000;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Double-buffered 8-digit common-anode scanner with dead-time blanking and
// optional leading-zero suppression; all pin outputs are registered.
//   state | meaning
//   BLANK | dead time at slot start, anodes and segments off
//   DRIVE | selected digit anode on, segments show its nibble
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter int DEAD    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        din_vld,
    input  logic        lz_en,
    output logic [6:0]  a2g,
    output logic [7:0]  an,
    output logic        frame
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DIGITS);
    localparam logic [CW-1:0] SLOT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

    seg7_state_t     r_state;
    logic [CW-1:0]   r_slot_cnt;
    logic [DW-1:0]   r_dig;
    logic [31:0]     r_pend;
    logic [31:0]     r_disp;
    logic [6:0]      r_a2g;
    logic [7:0]      r_an;
    logic            r_frame;

    seg7_state_t     w_state_nxt;
    logic [CW-1:0]   w_slot_nxt;
    logic [DW-1:0]   w_dig_nxt;
    logic            w_slot_last;
    logic [3:0]      w_nibble;
    logic [6:0]      w_seg;
    logic            w_lz_blank;
    logic [6:0]      w_a2g_nxt;
    logic [7:0]      w_an_nxt;
    logic            w_frame_nxt;

    assign w_slot_last = (r_slot_cnt == SLOT_LAST);
    assign w_nibble    = r_disp[{r_dig, 2'b00} +: 4];
    // Digit 0 always lights so a zero value still shows "0".
    assign w_lz_blank  = lz_en && (r_dig != '0) && ((r_disp >> {r_dig, 2'b00}) == 32'd0);

    seg7_dec u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BLANK;
            r_slot_cnt <= '0;
            r_dig      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot_cnt <= w_slot_nxt;
            r_dig      <= w_dig_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot_cnt + 1'b1;
        w_dig_nxt   = r_dig;
        if (w_slot_last) begin
            w_slot_nxt  = '0;
            w_dig_nxt   = r_dig + 1'b1;
            w_state_nxt = BLANK;
        end else if (r_state == BLANK && r_slot_cnt == DEAD_LAST) begin
            w_state_nxt = DRIVE;
        end
    end

    // Outputs are computed from the next state so the pins switch on the same edge as the FSM.
    always_comb begin
        w_an_nxt    = AN_OFF;
        w_a2g_nxt   = SEG_OFF;
        w_frame_nxt = (w_slot_nxt == SLOT_LAST) && (w_dig_nxt == DIG_LAST);
        if (w_state_nxt == DRIVE && !w_lz_blank) begin
            w_an_nxt  = ~(8'h01 << r_dig);
            w_a2g_nxt = w_seg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an    <= AN_OFF;
            r_a2g   <= SEG_OFF;
            r_frame <= 1'b0;
            r_pend  <= '0;
            r_disp  <= '0;
        end else begin
            r_an    <= w_an_nxt;
            r_a2g   <= w_a2g_nxt;
            r_frame <= w_frame_nxt;
            if (din_vld)
                r_pend <= din;
            // A strobe on the frame edge bypasses pend so it is not delayed a whole frame.
            if (r_frame)
                r_disp <= din_vld ? din : r_pend;
        end
    end

    assign an    = r_an;
    assign a2g   = r_a2g;
    assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: expected per-digit patterns are queued when a value is strobed.
module tb_seg7_scan;

    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din = '0;
    logic        din_vld = 1'b0;
    logic        lz_en = 1'b0;
    logic [6:0]  a2g;
    logic [7:0]  an;
    logic        frame;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t sb[$];

    seg7_scan #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .lz_en   (lz_en),
        .a2g     (a2g),
        .an      (an),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic push_frame(input logic [31:0] v, input logic lz);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (lz && i > 0 && (v >> (4 * i)) == 32'd0) begin
                e.an  = 8'hFF;
                e.seg = 7'h7F;
            end else begin
                e.an  = ~(8'h01 << i);
                e.seg = hex7(v[4 * i +: 4]);
            end
            sb.push_back(e);
        end
    endtask

    task automatic strobe(input logic [31:0] v);
        din     = v;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    task automatic wait_frame();
        bit found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (frame === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_frame: frame=%b, required a pulse within 200 clocks", frame);
        end
    endtask

    // Starts right after a negedge where frame=1; covers exactly one frame.
    task automatic capture_frame(input string tag);
        exp_t e;
        logic exp_frame;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                if (d == 0 && c == 0) din_vld = 1'b0;
                if (c < DEAD) begin
                    checks++;
                    if (an !== 8'hFF || a2g !== 7'h7F) begin
                        errors++;
                        $display("FAIL %s dead d%0d c%0d: an=%h a2g=%b, required an=ff a2g=1111111", tag, d, c, an, a2g);
                    end
                end
                if (c == 4) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL %s scoreboard d%0d: queue empty, required an entry", tag, d);
                    end else begin
                        e = sb.pop_front();
                        if (an !== e.an) begin
                            errors++;
                            $display("FAIL %s an d%0d: got %h, required %h", tag, d, an, e.an);
                        end
                        if (e.an != 8'hFF) begin
                            checks++;
                            if (a2g !== e.seg) begin
                                errors++;
                                $display("FAIL %s a2g d%0d: got %b, required %b", tag, d, a2g, e.seg);
                            end
                        end
                    end
                end
                exp_frame = (d == 7 && c == CLK_DIV - 1);
                checks++;
                if (frame !== exp_frame) begin
                    errors++;
                    $display("FAIL %s frame d%0d c%0d: got %b, required %b", tag, d, c, frame, exp_frame);
                end
            end
        end
    endtask

    task automatic check_restart(input string tag);
        @(negedge clk);
        checks++;
        if (an !== 8'hFF || a2g !== 7'h7F) begin
            errors++;
            $display("FAIL %s first blank: an=%h a2g=%b, required ff 1111111", tag, an, a2g);
        end
        @(negedge clk);
        checks++;
        if (an !== 8'hFE || a2g !== 7'b0000001) begin
            errors++;
            $display("FAIL %s first drive: an=%h a2g=%b, required fe 0000001", tag, an, a2g);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 8'hFF || a2g !== 7'h7F || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset hold: an=%h a2g=%b frame=%b, required ff 1111111 0", an, a2g, frame);
        end
        rst = 1'b1;
        check_restart("reset");
    endtask

    task automatic test_load();
        strobe(32'h1234ABCD);
        repeat (8) @(negedge clk);
        checks++;
        if (an !== 8'hFD || a2g !== 7'b0000001) begin
            errors++;
            $display("FAIL load_before_frame: an=%h a2g=%b, required fd 0000001", an, a2g);
        end
        wait_frame();
        push_frame(32'h1234ABCD, 1'b0);
        capture_frame("load");
        push_frame(32'h1234ABCD, 1'b0);
        capture_frame("hold");
    endtask

    task automatic test_lz(input logic [31:0] v, input string tag);
        lz_en = 1'b1;
        repeat (5) @(negedge clk);
        strobe(v);
        wait_frame();
        push_frame(v, 1'b1);
        capture_frame(tag);
    endtask

    task automatic test_back_to_back();
        lz_en = 1'b0;
        repeat (3) @(negedge clk);
        strobe(32'h11111111);
        repeat (4) @(negedge clk);
        strobe(32'h22222222);
        wait_frame();
        push_frame(32'h22222222, 1'b0);
        capture_frame("last_wins");
        din     = 32'h33333333;
        din_vld = 1'b1;
        push_frame(32'h33333333, 1'b0);
        capture_frame("bypass");
    endtask

    task automatic test_reset_mid();
        repeat (4 * CLK_DIV + 5) @(negedge clk);
        checks++;
        if (an !== 8'hEF || a2g !== 7'b0000110) begin
            errors++;
            $display("FAIL mid_before: an=%h a2g=%b, required ef 0000110", an, a2g);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (an !== 8'hFF || a2g !== 7'h7F || frame !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: an=%h a2g=%b frame=%b, required ff 1111111 0", an, a2g, frame);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_restart("mid_restart");
        wait_frame();
        push_frame(32'h0, 1'b0);
        capture_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_load();
        test_lz(32'h00000F00, "lz_f00");
        test_lz(32'h00000000, "lz_zero");
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
